// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops words from a registered-read synchronous FIFO and
// sends each one on a UART TX line, LSB first: start bit, DATA_LEN data bits,
// optional even-parity bit, one stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit slot).
module uart_tx_fifo_drain #(
    parameter int DATA_LEN     = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                CLK_IW,
    input  logic                RST_N_IW,
    input  logic [DATA_LEN-1:0] FIFO_DATA_I,
    input  logic                FIFO_EMPTY_IW,
    output logic                FIFO_READ_EN_OR,
    output logic                TX_OR,
    output logic                BUSY_OW,
    output logic                FRAME_DONE_OR
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_LEN);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_LEN-1:0] shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                rd_en_q, rd_en_d;
    logic                done_q, done_d;
    logic                bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    assign bit_tick = (cnt_q == CNT_LAST);

    // Next-state and next-output logic; every output is registered so the line never glitches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        rd_en_d  = 1'b0;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                tx_d  = 1'b1;
                // Empty flag is only looked at here; once popped, the word is always sent.
                if (!FIFO_EMPTY_IW) begin
                    rd_en_d = 1'b1;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                // FIFO registers its output on this cycle's closing edge.
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d  = FIFO_DATA_I;
`ifdef UART_TX_PARITY_EN
                parity_d = ^FIFO_DATA_I;
`endif
                tx_d     = 1'b0;
                cnt_d    = '0;
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Registered pulse lands in the final stop-bit cycle.
                    if (cnt_q == CNT_PRE) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge CLK_IW) begin
        if (!RST_N_IW) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign TX_OR           = tx_q;
    assign FIFO_READ_EN_OR = rd_en_q;
    assign FRAME_DONE_OR   = done_q;
    assign BUSY_OW         = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Downstream consumer of the team's synchronous FIFO. It pops one word at a time from the FIFO and serialises it onto a UART TX line, LSB first: 1 start bit, DATA_LEN data bits, optional parity, 1 stop bit. It handles the FIFO's registered-read behaviour: data appears on the FIFO output one clock after the read strobe.

Parameters:
DATA_LEN, 8, word width; must match the FIFO DATA_LEN; legal range 5..9.
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.

Ports:
CLK_IW  in  1  system clock; all logic on its rising edge.
RST_N_IW  in  1  synchronous, active-low reset; sampled on the CLK_IW rising edge.
FIFO_DATA_I  in  DATA_LEN  FIFO DATA_OUT; valid the cycle after FIFO_READ_EN_OR is high.
FIFO_EMPTY_IW  in  1  FIFO EMPTY flag.
FIFO_READ_EN_OR  out  1  single-cycle pop strobe to the FIFO READ_EN.
TX_OR  out  1  serial line; idle high.
BUSY_OW  out  1  high from the pop strobe until the end of the stop bit.
FRAME_DONE_OR  out  1  single-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (RST_N_IW=0 at a clock edge) applies these values:
  - TX_OR=1, FIFO_READ_EN_OR=0, FRAME_DONE_OR=0, BUSY_OW=0.
  - State=IDLE; baud counter=0; bit index=0; shift register=0.
- Reset mid-frame aborts the frame at once. TX_OR returns high on the next edge. The popped word is lost; it is not re-read.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY (optional), STOP.
- IDLE: if FIFO_EMPTY_IW=0, drive FIFO_READ_EN_OR=1 for exactly one cycle and go to POP. Otherwise stay.
- POP: one wait cycle while the FIFO registers the output. FIFO_READ_EN_OR=0.
- LOAD: capture FIFO_DATA_I into the shift register. Go to START.
- Latency: TX_OR falls 3 clocks after the IDLE cycle that sees FIFO_EMPTY_IW=0.
- START: TX_OR=0 for CLKS_PER_BIT cycles.
- DATA: TX_OR = shift register bit 0 for CLKS_PER_BIT cycles per bit. Shift right at each bit boundary. After DATA_LEN bits go to PARITY, or to STOP when parity is disabled.
- STOP: TX_OR=1 for CLKS_PER_BIT cycles. FRAME_DONE_OR pulses in the final cycle. Then go to IDLE.
- Back-to-back words are not gapless. After STOP the block returns to IDLE, so frames are separated by 3 idle-high clocks (IDLE, POP, LOAD).
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0, and generates the bit-boundary tick at CLKS_PER_BIT-1. Counter is cleared on entry to START.
- FIFO_EMPTY_IW is sampled only in IDLE. An empty flag rising during POP or LOAD is ignored; the popped word is always sent.
- FIFO_READ_EN_OR is never asserted while FIFO_EMPTY_IW=1, and never more than once per frame.
- BUSY_OW = (state != IDLE). It is combinational from the state register.
- FIFO_DATA_I is sampled only in LOAD. Changes at any other time have no effect on the frame.
- TX_OR comes from a register, so the line is glitch-free.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP for CLKS_PER_BIT cycles.
  - TX_OR = even parity, i.e. the XOR of the captured word, computed at LOAD.
  - Frame length = DATA_LEN+3 bits.
- Undefined:
  - No PARITY state, no parity logic.
  - Frame length = DATA_LEN+2 bits.

Test Plan:
1. Reset idle: hold RST_N_IW=0 for 3 clocks with FIFO_EMPTY_IW=0 -> TX_OR=1, FIFO_READ_EN_OR=0, BUSY_OW=0 throughout.
2. Single frame, CLKS_PER_BIT=4, FIFO returns 0xA5 one clock after the pop:
   - exactly one pop strobe;
   - TX_OR sequence per 4-clock bit: 0, 1,0,1,0,0,1,0,1, 1;
   - FRAME_DONE_OR pulses once, in clock 40 of the frame;
   - BUSY_OW falls the next clock.
3. Back-to-back: FIFO holds 0x00 then 0xFF with EMPTY low for both -> two frames, separated by exactly 3 idle-high clocks; two pop strobes total.
4. Empty handling: FIFO_EMPTY_IW=1 for 50 clocks, then 0 -> no pop strobe while empty; first pop on the clock after EMPTY falls.
5. Reset mid-frame: assert RST_N_IW=0 during data bit 3 of 0x3C -> TX_OR=1 on the next edge, state IDLE. After release with FIFO non-empty, a new pop occurs and a full clean frame follows.
6. Parity (UART_TX_PARITY_EN defined): word 0x07 -> parity bit 1; word 0x03 -> parity bit 0; stop bit follows in the 11th bit slot.
